// File: rtl/sap_ring_controller_if.sv
// Control bundle between the SAP sequencer and the datapath it steers:
// the IR opcode flows in, the T-state, halt flag and every load/drive enable flow out.
interface sap_ring_controller_if #(
   parameter int OPW = 4,
   parameter int NT  = 6
);
   logic [OPW-1:0] i_opcode;
   logic [NT-1:0]  o_tstate;
   logic           o_halted;
   logic           o_pc_inc;
   logic           o_pc_out;
   logic           o_mar_en;
   logic           o_ram_out;
   logic           o_ir_en;
   logic           o_ir_out;
   logic           o_a_en;
   logic           o_a_out;
   logic           o_b_en;
   logic           o_alu_sub;
   logic           o_alu_out;
   logic           o_out_en;

   modport master (
      input  i_opcode,
      output o_tstate, o_halted, o_pc_inc, o_pc_out, o_mar_en, o_ram_out, o_ir_en,
             o_ir_out, o_a_en, o_a_out, o_b_en, o_alu_sub, o_alu_out, o_out_en
   );

   modport slave (
      output i_opcode,
      input  o_tstate, o_halted, o_pc_inc, o_pc_out, o_mar_en, o_ram_out, o_ir_en,
             o_ir_out, o_a_en, o_a_out, o_b_en, o_alu_sub, o_alu_out, o_out_en
   );
endinterface

// File: rtl/sap_ring_controller.sv
// SAP controller-sequencer: one-hot T1..T6 ring decoded with the IR opcode into
// the datapath load enables, bus drivers, PC and ALU controls; HLT freezes the ring.
module sap_ring_controller #(
   parameter int OPW = 4,
   parameter int NT  = 6
) (
   input  logic                   clk,
   input  logic                   clr,
   sap_ring_controller_if.master  bus
);
   localparam logic [NT-1:0]  T1_VEC = NT'(1);
   localparam logic [OPW-1:0] OP_LDA = OPW'(4'b0000);
   localparam logic [OPW-1:0] OP_ADD = OPW'(4'b0001);
   localparam logic [OPW-1:0] OP_SUB = OPW'(4'b0010);
   localparam logic [OPW-1:0] OP_OUT = OPW'(4'b1110);
   localparam logic [OPW-1:0] OP_HLT = OPW'(4'b1111);

   logic [NT-1:0] r_tstate;
   logic          r_halted;
   logic [NT-1:0] w_tstate_next;
   logic          w_halted_next;
   logic [NT-1:0] w_ring_rot;
   logic          w_onehot;
   logic          w_pc_inc, w_pc_out, w_mar_en, w_ram_out, w_ir_en, w_ir_out;
   logic          w_a_en, w_a_out, w_b_en, w_alu_sub, w_alu_out, w_out_en;

   assign w_onehot = (r_tstate != '0) && ((r_tstate & (r_tstate - T1_VEC)) == '0);

   genvar gi;
   generate
      for (gi = 0; gi < NT; gi++) begin : g_ring
         assign w_ring_rot[gi] = r_tstate[(gi + NT - 1) % NT];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (clr) begin
         r_tstate <= T1_VEC;
         r_halted <= 1'b0;
      end else begin
         r_tstate <= w_tstate_next;
         r_halted <= w_halted_next;
      end
   end

   // A corrupted ring recovers to T1 regardless of halt; HLT is caught at the end of T4.
   always_comb begin
      w_tstate_next = r_tstate;
      w_halted_next = r_halted;
      if (!w_onehot) begin
         w_tstate_next = T1_VEC;
      end else if (!r_halted) begin
         if (r_tstate[3] && (bus.i_opcode == OP_HLT)) begin
            w_halted_next = 1'b1;
         end else begin
            w_tstate_next = w_ring_rot;
         end
      end
   end

   always_comb begin
      w_pc_inc  = 1'b0;
      w_pc_out  = 1'b0;
      w_mar_en  = 1'b0;
      w_ram_out = 1'b0;
      w_ir_en   = 1'b0;
      w_ir_out  = 1'b0;
      w_a_en    = 1'b0;
      w_a_out   = 1'b0;
      w_b_en    = 1'b0;
      w_alu_sub = 1'b0;
      w_alu_out = 1'b0;
      w_out_en  = 1'b0;
      if (!r_halted && w_onehot) begin
         if (r_tstate[0]) begin
            w_pc_out = 1'b1;
            w_mar_en = 1'b1;
         end
         if (r_tstate[1]) begin
            w_pc_inc = 1'b1;
         end
         if (r_tstate[2]) begin
            w_ram_out = 1'b1;
            w_ir_en   = 1'b1;
         end
         if (r_tstate[3]) begin
            if ((bus.i_opcode == OP_LDA) || (bus.i_opcode == OP_ADD) || (bus.i_opcode == OP_SUB)) begin
               w_ir_out = 1'b1;
               w_mar_en = 1'b1;
            end else if (bus.i_opcode == OP_OUT) begin
               w_a_out  = 1'b1;
               w_out_en = 1'b1;
            end
         end
         if (r_tstate[4]) begin
            if (bus.i_opcode == OP_LDA) begin
               w_ram_out = 1'b1;
               w_a_en    = 1'b1;
            end else if ((bus.i_opcode == OP_ADD) || (bus.i_opcode == OP_SUB)) begin
               w_ram_out = 1'b1;
               w_b_en    = 1'b1;
            end
         end
         if (r_tstate[5]) begin
            if ((bus.i_opcode == OP_ADD) || (bus.i_opcode == OP_SUB)) begin
               w_alu_out = 1'b1;
               w_a_en    = 1'b1;
               w_alu_sub = (bus.i_opcode == OP_SUB);
            end
         end
      end
   end

   assign bus.o_tstate  = r_tstate;
   assign bus.o_halted  = r_halted;
   assign bus.o_pc_inc  = w_pc_inc;
   assign bus.o_pc_out  = w_pc_out;
   assign bus.o_mar_en  = w_mar_en;
   assign bus.o_ram_out = w_ram_out;
   assign bus.o_ir_en   = w_ir_en;
   assign bus.o_ir_out  = w_ir_out;
   assign bus.o_a_en    = w_a_en;
   assign bus.o_a_out   = w_a_out;
   assign bus.o_b_en    = w_b_en;
   assign bus.o_alu_sub = w_alu_sub;
   assign bus.o_alu_out = w_alu_out;
   assign bus.o_out_en  = w_out_en;
endmodule

// File: tb/tb_sap_ring_controller.sv
// Directed bench for sap_ring_controller: a step-count/halt-flag model is checked
// every cycle, with literal microcode expectations pinning the model.
module tb_sap_ring_controller;
   // control vector bit positions
   localparam logic [11:0] C_PC_INC  = 12'h800;
   localparam logic [11:0] C_PC_OUT  = 12'h400;
   localparam logic [11:0] C_MAR_EN  = 12'h200;
   localparam logic [11:0] C_RAM_OUT = 12'h100;
   localparam logic [11:0] C_IR_EN   = 12'h080;
   localparam logic [11:0] C_IR_OUT  = 12'h040;
   localparam logic [11:0] C_A_EN    = 12'h020;
   localparam logic [11:0] C_A_OUT   = 12'h010;
   localparam logic [11:0] C_B_EN    = 12'h008;
   localparam logic [11:0] C_ALU_SUB = 12'h004;
   localparam logic [11:0] C_ALU_OUT = 12'h002;
   localparam logic [11:0] C_OUT_EN  = 12'h001;

   logic clk = 1'b0;
   logic clr = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   m_t     = 1;
   bit   m_h     = 1'b0;
   logic [11:0] got_ctrl;
   logic [4:0]  got_drv;

   sap_ring_controller_if #(.OPW(4), .NT(6)) bus ();

   sap_ring_controller #(.OPW(4), .NT(6)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign got_ctrl = {bus.o_pc_inc, bus.o_pc_out, bus.o_mar_en, bus.o_ram_out, bus.o_ir_en,
                      bus.o_ir_out, bus.o_a_en, bus.o_a_out, bus.o_b_en, bus.o_alu_sub,
                      bus.o_alu_out, bus.o_out_en};
   assign got_drv  = {bus.o_pc_out, bus.o_ram_out, bus.o_ir_out, bus.o_a_out, bus.o_alu_out};

   function automatic logic [11:0] exp_ctrl(input int t, input logic [3:0] op, input bit h);
      logic [11:0] c;
      bit mem_op;
      c = 12'h000;
      mem_op = (op == 4'h0) || (op == 4'h1) || (op == 4'h2);
      if (!h) begin
         case (t)
            1: c = C_PC_OUT | C_MAR_EN;
            2: c = C_PC_INC;
            3: c = C_RAM_OUT | C_IR_EN;
            4: if (mem_op) c = C_IR_OUT | C_MAR_EN;
               else if (op == 4'hE) c = C_A_OUT | C_OUT_EN;
            5: if (op == 4'h0) c = C_RAM_OUT | C_A_EN;
               else if (mem_op) c = C_RAM_OUT | C_B_EN;
            6: if (op == 4'h1) c = C_ALU_OUT | C_A_EN;
               else if (op == 4'h2) c = C_ALU_OUT | C_ALU_SUB | C_A_EN;
            default: c = 12'h000;
         endcase
      end
      return c;
   endfunction

   task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0d)", name, got, exp, $time);
      end
   endtask

   // One clock: apply inputs, advance the model, compare everything at the negedge.
   task automatic cyc(input logic c, input logic [3:0] op);
      logic [5:0] one;
      logic [5:0] exp_ts;
      int ndrv;
      clr = c;
      bus.i_opcode = op;
      @(posedge clk);
      if (c) begin
         m_t = 1;
         m_h = 1'b0;
      end else if (!m_h) begin
         if (m_t == 4 && op == 4'hF) m_h = 1'b1;
         else m_t = (m_t == 6) ? 1 : m_t + 1;
      end
      @(negedge clk);
      one = 6'b000001;
      exp_ts = one << (m_t - 1);
      chk("tstate", {6'b0, bus.o_tstate}, {6'b0, exp_ts});
      chk("halted", {11'b0, bus.o_halted}, {11'b0, m_h});
      chk("ctrl", got_ctrl, exp_ctrl(m_t, bus.i_opcode, m_h));
      ndrv = 0;
      for (int i = 0; i < 5; i++) ndrv += int'(got_drv[i]);
      chk("bus_drivers_le1", 12'(ndrv > 1), 12'h000);
      $display("[TB] clr=%0b op=%h tstate=%b halted=%0b ctrl=%h", c, op, bus.o_tstate, bus.o_halted, got_ctrl);
   endtask

   // Fetch with scrambled opcode during T1..T3, then present op from T4; ends observing T4.
   task automatic fetch_to_t4(input logic [3:0] op, input logic [3:0] junk);
      cyc(1'b0, junk);
      chk("lit_T2_ctrl", got_ctrl, C_PC_INC);
      cyc(1'b0, ~junk);
      chk("lit_T3_ctrl", got_ctrl, C_RAM_OUT | C_IR_EN);
      cyc(1'b0, op);
      chk("lit_T4_tstate", {6'b0, bus.o_tstate}, 12'h008);
   endtask

   initial begin
      bus.i_opcode = 4'h0;
      cyc(1'b1, 4'h0);
      cyc(1'b1, 4'h0);
      chk("lit_reset_tstate", {6'b0, bus.o_tstate}, 12'h001);
      chk("lit_reset_halted", {11'b0, bus.o_halted}, 12'h000);
      chk("lit_reset_ctrl", got_ctrl, C_PC_OUT | C_MAR_EN);

      // LDA
      fetch_to_t4(4'h0, 4'h7);
      chk("lit_LDA_T4", got_ctrl, C_IR_OUT | C_MAR_EN);
      cyc(1'b0, 4'h0);
      chk("lit_LDA_T5", got_ctrl, C_RAM_OUT | C_A_EN);
      cyc(1'b0, 4'h0);
      chk("lit_LDA_T6", got_ctrl, 12'h000);
      cyc(1'b0, 4'h0);
      chk("lit_LDA_wrap", {6'b0, bus.o_tstate}, 12'h001);

      // ADD
      fetch_to_t4(4'h1, 4'hF);
      cyc(1'b0, 4'h1);
      chk("lit_ADD_T5", got_ctrl, C_RAM_OUT | C_B_EN);
      cyc(1'b0, 4'h1);
      chk("lit_ADD_T6", got_ctrl, C_ALU_OUT | C_A_EN);
      cyc(1'b0, 4'h1);

      // SUB
      fetch_to_t4(4'h2, 4'hE);
      cyc(1'b0, 4'h2);
      chk("lit_SUB_T5", got_ctrl, C_RAM_OUT | C_B_EN);
      cyc(1'b0, 4'h2);
      chk("lit_SUB_T6", got_ctrl, C_ALU_OUT | C_ALU_SUB | C_A_EN);
      cyc(1'b0, 4'h2);

      // OUT
      fetch_to_t4(4'hE, 4'h2);
      chk("lit_OUT_T4", got_ctrl, C_A_OUT | C_OUT_EN);
      cyc(1'b0, 4'hE);
      chk("lit_OUT_T5", got_ctrl, 12'h000);
      cyc(1'b0, 4'hE);
      chk("lit_OUT_T6", got_ctrl, 12'h000);
      cyc(1'b0, 4'hE);

      // unknown opcode behaves as NOP
      fetch_to_t4(4'h5, 4'h1);
      chk("lit_NOP_T4", got_ctrl, 12'h000);
      cyc(1'b0, 4'h5);
      cyc(1'b0, 4'h5);
      chk("lit_NOP_T6", got_ctrl, 12'h000);
      cyc(1'b0, 4'h5);
      chk("lit_NOP_wrap", {6'b0, bus.o_tstate}, 12'h001);

      // HLT: halts at the end of T4 and stays frozen
      fetch_to_t4(4'hF, 4'h0);
      chk("lit_HLT_T4", got_ctrl, 12'h000);
      cyc(1'b0, 4'hF);
      chk("lit_HLT_halted", {11'b0, bus.o_halted}, 12'h001);
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, 4'(i));
         chk("lit_HLT_hold", {6'b0, bus.o_tstate}, 12'h008);
         chk("lit_HLT_ctrl", got_ctrl, 12'h000);
      end
      cyc(1'b1, 4'hF);
      chk("lit_HLT_clr_tstate", {6'b0, bus.o_tstate}, 12'h001);
      chk("lit_HLT_clr_halted", {11'b0, bus.o_halted}, 12'h000);

      // clr in T5 of an ADD
      fetch_to_t4(4'h1, 4'h3);
      cyc(1'b0, 4'h1);
      chk("lit_mid_T5", got_ctrl, C_RAM_OUT | C_B_EN);
      cyc(1'b1, 4'h1);
      chk("lit_mid_clr_tstate", {6'b0, bus.o_tstate}, 12'h001);
      chk("lit_mid_clr_ctrl", got_ctrl, C_PC_OUT | C_MAR_EN);

      // a full instruction after the mid-instruction reset
      for (int i = 0; i < 6; i++) cyc(1'b0, 4'h2);
      chk("lit_final_wrap", {6'b0, bus.o_tstate}, 12'h001);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
